// File: rtl/cram_arb4.sv
// cram_arb4: four-port round-robin command arbiter in front of the CellularRAM controller.
// Build option CRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority; ports 1..3 stay round-robin.
module cram_arb4 #(
  parameter logic [29:0] ADDR_MASK = 30'h00FF_FFFF,
  parameter logic [3:0]  PORT_EN   = 4'b1111
) (
  input  logic         mem_clk,
  input  logic         mem_rst_n,
  input  logic         init_done,
  input  logic [3:0]   port_cmd_req,
  input  logic [11:0]  port_cmd_instr,
  input  logic [23:0]  port_cmd_bl,
  input  logic [119:0] port_cmd_addr,
  output logic [3:0]   port_cmd_ack,
  input  logic [127:0] port_wr_data,
  input  logic [15:0]  port_wr_mask,
  output logic [3:0]   port_wr_ack,
  output logic [3:0]   port_rd_valid,
  output logic [31:0]  port_rd_data,
  output logic         mem_cmd_req,
  output logic [2:0]   mem_cmd_instr,
  output logic [5:0]   mem_cmd_bl,
  output logic [29:0]  mem_cmd_byte_addr,
  output logic [2:0]   mem_cmd_master,
  input  logic         mem_cmd_ack,
  output logic [31:0]  mem_wr_data,
  output logic [3:0]   mem_wr_mask,
  input  logic         mem_wr_ack,
  input  logic [2:0]   mem_wr_master,
  input  logic         mem_rd_req,
  input  logic [31:0]  mem_rd_data,
  input  logic [2:0]   mem_rd_master,
  output logic         arb_busy,
  output logic [1:0]   arb_grant
);

  localparam int unsigned NPORT = 4;
  localparam int unsigned AW    = 30;
  localparam int unsigned DW    = 32;
  localparam int unsigned BLW   = 6;
  localparam int unsigned IW    = 3;
  localparam int unsigned MW    = 4;
  localparam int unsigned CW    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [1:0]      rr_ptr, rr_ptr_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            is_write, is_write_d;
  logic [1:0]      arb_grant_d;
  logic            arb_busy_d;
  logic            mem_cmd_req_d;
  logic [IW-1:0]   mem_cmd_instr_d;
  logic [BLW-1:0]  mem_cmd_bl_d;
  logic [AW-1:0]   mem_cmd_byte_addr_d;
  logic [2:0]      mem_cmd_master_d;
  logic [3:0]      port_cmd_ack_d;

  logic [IW-1:0]   instr_a [NPORT];
  logic [BLW-1:0]  bl_a    [NPORT];
  logic [AW-1:0]   addr_a  [NPORT];
  logic [DW-1:0]   wdata_a [NPORT];
  logic [MW-1:0]   wmask_a [NPORT];

  logic [3:0]      req_en;
  logic            sel_vld;
  logic [1:0]      sel_port;
  logic [1:0]      idx;
  logic [1:0]      next_ptr;
  logic            beat;

  // The write master id is implied by the held grant, so it is not decoded.
  logic            unused_wr_master;
  assign unused_wr_master = ^mem_wr_master;

  // Unpack per-port command and write-data slices.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      instr_a[i] = port_cmd_instr[i*IW +: IW];
      bl_a[i]    = port_cmd_bl[i*BLW +: BLW];
      addr_a[i]  = port_cmd_addr[i*AW +: AW];
      wdata_a[i] = port_wr_data[i*DW +: DW];
      wmask_a[i] = port_wr_mask[i*MW +: MW];
    end
  end

  // Port selection: first enabled requester at or after rr_ptr.
  always_comb begin
    req_en   = port_cmd_req & PORT_EN;
    sel_vld  = 1'b0;
    sel_port = 2'd0;
    idx      = 2'd0;
`ifdef CRAM_ARB_FIXED_PRIO_EN
    if (req_en[0]) begin
      sel_vld  = 1'b1;
      sel_port = 2'd0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        idx = rr_ptr + 2'(k);
        if (!sel_vld && (idx != 2'd0) && req_en[idx]) begin
          sel_vld  = 1'b1;
          sel_port = idx;
        end
      end
    end
    next_ptr = (arb_grant != 2'd0) ? arb_grant + 2'd1 : rr_ptr;
`else
    for (int k = 0; k < NPORT; k++) begin
      idx = rr_ptr + 2'(k);
      if (!sel_vld && req_en[idx]) begin
        sel_vld  = 1'b1;
        sel_port = idx;
      end
    end
    next_ptr = arb_grant + 2'd1;
`endif
  end

  // A beat counts only in XFER and only on the strobe matching the direction.
  always_comb begin
    if (is_write) begin
      beat = (state == XFER) && mem_wr_ack;
    end else begin
      beat = (state == XFER) && mem_rd_req && (mem_rd_master == {1'b0, arb_grant});
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d             = state;
    rr_ptr_d            = rr_ptr;
    cnt_d               = cnt;
    is_write_d          = is_write;
    arb_grant_d         = arb_grant;
    mem_cmd_req_d       = mem_cmd_req;
    mem_cmd_instr_d     = mem_cmd_instr;
    mem_cmd_bl_d        = mem_cmd_bl;
    mem_cmd_byte_addr_d = mem_cmd_byte_addr;
    mem_cmd_master_d    = mem_cmd_master;
    port_cmd_ack_d      = 4'b0000;
    case (state)
      IDLE: begin
        if (init_done && sel_vld) begin
          state_d             = REQ;
          arb_grant_d         = sel_port;
          mem_cmd_req_d       = 1'b1;
          mem_cmd_instr_d     = instr_a[sel_port];
          mem_cmd_bl_d        = bl_a[sel_port];
          mem_cmd_byte_addr_d = addr_a[sel_port] & ADDR_MASK;
          mem_cmd_master_d    = {1'b0, sel_port};
          is_write_d          = ~instr_a[sel_port][0];
          cnt_d               = {1'b0, bl_a[sel_port]} + 7'd1;
        end
      end
      REQ: begin
        if (mem_cmd_ack) begin
          state_d        = XFER;
          mem_cmd_req_d  = 1'b0;
          port_cmd_ack_d = 4'b0001 << arb_grant;
        end
      end
      XFER: begin
        if (beat) begin
          if (cnt == 7'd1) begin
            state_d  = IDLE;
            cnt_d    = 7'd0;
            rr_ptr_d = next_ptr;
          end else begin
            cnt_d = cnt - 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state             <= IDLE;
      rr_ptr            <= 2'd0;
      cnt               <= 7'd0;
      is_write          <= 1'b0;
      arb_grant         <= 2'd0;
      arb_busy          <= 1'b0;
      mem_cmd_req       <= 1'b0;
      mem_cmd_instr     <= 3'd0;
      mem_cmd_bl        <= 6'd0;
      mem_cmd_byte_addr <= 30'd0;
      mem_cmd_master    <= 3'd0;
      port_cmd_ack      <= 4'b0000;
    end else begin
      state             <= state_d;
      rr_ptr            <= rr_ptr_d;
      cnt               <= cnt_d;
      is_write          <= is_write_d;
      arb_grant         <= arb_grant_d;
      arb_busy          <= arb_busy_d;
      mem_cmd_req       <= mem_cmd_req_d;
      mem_cmd_instr     <= mem_cmd_instr_d;
      mem_cmd_bl        <= mem_cmd_bl_d;
      mem_cmd_byte_addr <= mem_cmd_byte_addr_d;
      mem_cmd_master    <= mem_cmd_master_d;
      port_cmd_ack      <= port_cmd_ack_d;
    end
  end

  // Data steering; write data parks at 0 / all-masked while no grant is held.
  always_comb begin
    mem_wr_data  = arb_busy ? wdata_a[arb_grant] : 32'd0;
    mem_wr_mask  = arb_busy ? wmask_a[arb_grant] : 4'hF;
    port_wr_ack  = (state == XFER && is_write && mem_wr_ack) ? (4'b0001 << arb_grant) : 4'b0000;
    port_rd_data = mem_rd_data;
    for (int i = 0; i < NPORT; i++) begin
      port_rd_valid[i] = mem_rd_req && (mem_rd_master == 3'(i)) && PORT_EN[i];
    end
  end

endmodule

// File: tb/tb_cram_arb4.sv
// tb_cram_arb4: directed self-checking bench for cram_arb4 with a simple controller model.
module tb_cram_arb4;

  logic         mem_clk;
  logic         mem_rst_n;
  logic         init_done;
  logic [3:0]   port_cmd_req;
  logic [3:0]   req2;
  logic [11:0]  port_cmd_instr;
  logic [23:0]  port_cmd_bl;
  logic [119:0] port_cmd_addr;
  logic [127:0] port_wr_data;
  logic [15:0]  port_wr_mask;
  logic         mem_cmd_ack;
  logic         mem_wr_ack;
  logic [2:0]   mem_wr_master;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_data;
  logic [2:0]   mem_rd_master;

  logic [3:0]   port_cmd_ack;
  logic [3:0]   port_wr_ack;
  logic [3:0]   port_rd_valid;
  logic [31:0]  port_rd_data;
  logic         mem_cmd_req;
  logic [2:0]   mem_cmd_instr;
  logic [5:0]   mem_cmd_bl;
  logic [29:0]  mem_cmd_byte_addr;
  logic [2:0]   mem_cmd_master;
  logic [31:0]  mem_wr_data;
  logic [3:0]   mem_wr_mask;
  logic         arb_busy;
  logic [1:0]   arb_grant;

  logic [3:0]   d2_port_cmd_ack;
  logic [3:0]   d2_port_rd_valid;
  logic         d2_mem_cmd_req;
  logic         d2_arb_busy;
  logic [3:0]   unused_d2_wr_ack;
  logic [31:0]  unused_d2_rd_data;
  logic [2:0]   unused_d2_instr;
  logic [5:0]   unused_d2_bl;
  logic [29:0]  unused_d2_addr;
  logic [2:0]   unused_d2_master;
  logic [31:0]  unused_d2_wr_data;
  logic [3:0]   unused_d2_wr_mask;
  logic [1:0]   unused_d2_grant;

  int errors = 0;
  int checks = 0;

  cram_arb4 dut (
    .mem_clk(mem_clk), .mem_rst_n(mem_rst_n), .init_done(init_done),
    .port_cmd_req(port_cmd_req), .port_cmd_instr(port_cmd_instr), .port_cmd_bl(port_cmd_bl),
    .port_cmd_addr(port_cmd_addr), .port_cmd_ack(port_cmd_ack), .port_wr_data(port_wr_data),
    .port_wr_mask(port_wr_mask), .port_wr_ack(port_wr_ack), .port_rd_valid(port_rd_valid),
    .port_rd_data(port_rd_data), .mem_cmd_req(mem_cmd_req), .mem_cmd_instr(mem_cmd_instr),
    .mem_cmd_bl(mem_cmd_bl), .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_master(mem_cmd_master),
    .mem_cmd_ack(mem_cmd_ack), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .mem_wr_ack(mem_wr_ack), .mem_wr_master(mem_wr_master), .mem_rd_req(mem_rd_req),
    .mem_rd_data(mem_rd_data), .mem_rd_master(mem_rd_master), .arb_busy(arb_busy),
    .arb_grant(arb_grant)
  );

  cram_arb4 #(.PORT_EN(4'b1101)) dut2 (
    .mem_clk(mem_clk), .mem_rst_n(mem_rst_n), .init_done(init_done),
    .port_cmd_req(req2), .port_cmd_instr(port_cmd_instr), .port_cmd_bl(port_cmd_bl),
    .port_cmd_addr(port_cmd_addr), .port_cmd_ack(d2_port_cmd_ack), .port_wr_data(port_wr_data),
    .port_wr_mask(port_wr_mask), .port_wr_ack(unused_d2_wr_ack), .port_rd_valid(d2_port_rd_valid),
    .port_rd_data(unused_d2_rd_data), .mem_cmd_req(d2_mem_cmd_req), .mem_cmd_instr(unused_d2_instr),
    .mem_cmd_bl(unused_d2_bl), .mem_cmd_byte_addr(unused_d2_addr), .mem_cmd_master(unused_d2_master),
    .mem_cmd_ack(mem_cmd_ack), .mem_wr_data(unused_d2_wr_data), .mem_wr_mask(unused_d2_wr_mask),
    .mem_wr_ack(mem_wr_ack), .mem_wr_master(mem_wr_master), .mem_rd_req(mem_rd_req),
    .mem_rd_data(mem_rd_data), .mem_rd_master(mem_rd_master), .arb_busy(d2_arb_busy),
    .arb_grant(unused_d2_grant)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit wr, input logic [5:0] bl, input logic [29:0] a);
    port_cmd_instr[p*3 +: 3] = {2'b00, ~wr};
    port_cmd_bl[p*6 +: 6]    = bl;
    port_cmd_addr[p*30 +: 30] = a;
    port_wr_data[p*32 +: 32] = 32'hD0D0_0000 | 32'(p + 1);
    port_wr_mask[p*4 +: 4]   = 4'(p + 3);
  endtask

  // Controller model for one granted transfer: wait for the command, ack, then feed beats.
  task automatic run_xfer(input int port, input bit wr, input int beats,
                          input logic [29:0] exp_addr, input string tag);
    int n;
    int strobes;
    logic [3:0] onehot;
    logic [31:0] rdv;
    onehot = 4'b0001 << port;
    n = 0;
    while (mem_cmd_req !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({tag, "_cmd_req"}, 32'(mem_cmd_req), 32'd1);
    check({tag, "_grant"}, 32'(arb_grant), 32'(port));
    check({tag, "_master"}, 32'(mem_cmd_master), 32'(port));
    check({tag, "_addr"}, 32'(mem_cmd_byte_addr), 32'(exp_addr));
    check({tag, "_bl"}, 32'(mem_cmd_bl), 32'(beats - 1));
    check({tag, "_instr"}, 32'(mem_cmd_instr), {31'd0, ~wr});
    mem_cmd_ack = 1'b1;
    step();
    mem_cmd_ack = 1'b0;
    check({tag, "_port_ack"}, 32'(port_cmd_ack), 32'(onehot));
    check({tag, "_req_drop"}, 32'(mem_cmd_req), 32'd0);
    port_cmd_req[port] = 1'b0;
    // Wrong-direction / wrong-master strobes must not count as beats.
    if (wr) begin
      mem_rd_req    = 1'b1;
      mem_rd_master = 3'(port);
    end else begin
      mem_wr_ack    = 1'b1;
      mem_rd_req    = 1'b1;
      mem_rd_master = 3'((port + 1) % 4);
    end
    #1;
    check({tag, "_noise_wr_ack"}, 32'(port_wr_ack), 32'd0);
    if (wr) begin
      check({tag, "_wr_data"}, mem_wr_data, 32'hD0D0_0000 | 32'(port + 1));
      check({tag, "_wr_mask"}, 32'(mem_wr_mask), 32'(port + 3));
    end
    step();
    mem_wr_ack = 1'b0;
    mem_rd_req = 1'b0;
    check({tag, "_ack_pulse"}, 32'(port_cmd_ack), 32'd0);
    strobes = 0;
    for (int b = 0; b < beats; b++) begin
      if (b == beats - 1) check({tag, "_busy_last"}, 32'(arb_busy), 32'd1);
      rdv = 32'hA500_0000 + 32'(b);
      if (wr) begin
        mem_wr_ack    = 1'b1;
        mem_wr_master = 3'(port);
      end else begin
        mem_rd_req    = 1'b1;
        mem_rd_master = 3'(port);
        mem_rd_data   = rdv;
      end
      #1;
      if (wr && port_wr_ack == onehot) strobes++;
      if (!wr && port_rd_valid == onehot) strobes++;
      if (!wr && b == 0) check({tag, "_rd_data"}, port_rd_data, rdv);
      step();
      mem_wr_ack = 1'b0;
      mem_rd_req = 1'b0;
    end
    check({tag, "_strobes"}, 32'(strobes), 32'(beats));
    check({tag, "_done"}, 32'(arb_busy), 32'd0);
  endtask

  initial begin
    int first;
    int second;
    int exp_h;
    int seen;
    mem_rst_n = 1'b1;
    init_done = 1'b1;
    port_cmd_req = 4'd0;
    req2 = 4'd0;
    port_cmd_instr = '0;
    port_cmd_bl = '0;
    port_cmd_addr = '0;
    port_wr_data = '0;
    port_wr_mask = '0;
    mem_cmd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    mem_wr_master = 3'd0;
    mem_rd_req = 1'b0;
    mem_rd_data = 32'd0;
    mem_rd_master = 3'd0;
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 6'd0, 30'd0);

    // Reset values
    #3 mem_rst_n = 1'b0;
    step();
    step();
    check("rst_cmd_req", 32'(mem_cmd_req), 32'd0);
    check("rst_cmd_addr", 32'(mem_cmd_byte_addr), 32'd0);
    check("rst_wr_data", mem_wr_data, 32'd0);
    check("rst_wr_mask", 32'(mem_wr_mask), 32'hF);
    check("rst_busy", 32'(arb_busy), 32'd0);
    check("rst_grant", 32'(arb_grant), 32'd0);
    check("rst_port_ack", 32'(port_cmd_ack), 32'd0);
    @(negedge mem_clk);
    mem_rst_n = 1'b1;
    step();

    // Port 1 write, two beats
    set_port(1, 1'b1, 6'd1, 30'h0000_0100);
    port_cmd_req = 4'b0010;
    run_xfer(1, 1'b1, 2, 30'h0000_0100, "p1_wr");

    // rr_ptr is now 2: ports 0 and 2 request together
    set_port(0, 1'b0, 6'd0, 30'h0000_0010);
    set_port(2, 1'b0, 6'd0, 30'h0000_0020);
    port_cmd_req = 4'b0101;
`ifdef CRAM_ARB_FIXED_PRIO_EN
    first = 0; second = 2;
`else
    first = 2; second = 0;
`endif
    run_xfer(first, 1'b0, 1, 30'h0000_0010 + 30'(first * 8), "rr_first");
    run_xfer(second, 1'b0, 1, 30'h0000_0010 + 30'(second * 8), "rr_second");

    // Address masking
    set_port(3, 1'b0, 6'd0, 30'h3FFF_FFFC);
    port_cmd_req = 4'b1000;
    run_xfer(3, 1'b0, 1, 30'h00FF_FFFC, "mask");

    // Maximum burst: 64 read beats on port 3
    set_port(3, 1'b0, 6'h3F, 30'h0000_0400);
    port_cmd_req = 4'b1000;
    run_xfer(3, 1'b0, 64, 30'h0000_0400, "bl64");

    // Simultaneous reads on 0,2,3 with rr_ptr back at 0
    set_port(0, 1'b0, 6'd0, 30'h0000_1000);
    set_port(2, 1'b0, 6'd0, 30'h0000_2000);
    set_port(3, 1'b0, 6'd0, 30'h0000_3000);
    port_cmd_req = 4'b1101;
    run_xfer(0, 1'b0, 1, 30'h0000_1000, "sim_p0");
    run_xfer(2, 1'b0, 1, 30'h0000_2000, "sim_p2");
    run_xfer(3, 1'b0, 1, 30'h0000_3000, "sim_p3");

    // Strobes while idle: no port write ack, read valid still decodes
    mem_rd_req = 1'b1;
    mem_rd_master = 3'd2;
    mem_wr_ack = 1'b1;
    #1;
    check("idle_rd_valid", 32'(port_rd_valid), 32'b0100);
    check("idle_wr_ack", 32'(port_wr_ack), 32'd0);
    step();
    check("idle_busy", 32'(arb_busy), 32'd0);
    mem_rd_master = 3'd1;
    #1;
    check("d2_rd_valid_dis", 32'(d2_port_rd_valid), 32'd0);
    mem_rd_req = 1'b0;
    mem_wr_ack = 1'b0;

    // Disabled port 1 on the second instance is never granted
    req2 = 4'b0010;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (d2_mem_cmd_req !== 1'b0 || d2_port_cmd_ack !== 4'd0 || d2_arb_busy !== 1'b0) seen++;
    end
    check("d2_never_granted", 32'(seen), 32'd0);
    req2 = 4'b0000;

    // Port 1 write moves rr_ptr to 2
    set_port(1, 1'b1, 6'd0, 30'h0000_0200);
    port_cmd_req = 4'b0010;
    run_xfer(1, 1'b1, 1, 30'h0000_0200, "p1_again");

    // init_done low blocks grants
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 6'd7, 30'h0000_4000);
    init_done = 1'b0;
    port_cmd_req = 4'hF;
    step();
    step();
    step();
    check("init_blk_req", 32'(mem_cmd_req), 32'd0);
    check("init_blk_busy", 32'(arb_busy), 32'd0);
    init_done = 1'b1;
    step();
`ifdef CRAM_ARB_FIXED_PRIO_EN
    exp_h = 0;
`else
    exp_h = 2;
`endif
    check("init_req", 32'(mem_cmd_req), 32'd1);
    check("init_grant", 32'(arb_grant), 32'(exp_h));
    mem_cmd_ack = 1'b1;
    step();
    mem_cmd_ack = 1'b0;
    check("init_port_ack", 32'(port_cmd_ack), 32'(4'b0001 << exp_h));
    port_cmd_req[exp_h] = 1'b0;

    // Reset after 3 of 8 write beats
    mem_wr_ack = 1'b1;
    mem_wr_master = 3'(exp_h);
    step();
    step();
    step();
    check("mid_busy", 32'(arb_busy), 32'd1);
    #2 mem_rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(arb_busy), 32'd0);
    check("arst_grant", 32'(arb_grant), 32'd0);
    check("arst_cmd_req", 32'(mem_cmd_req), 32'd0);
    check("arst_master", 32'(mem_cmd_master), 32'd0);
    check("arst_addr", 32'(mem_cmd_byte_addr), 32'd0);
    check("arst_wr_data", mem_wr_data, 32'd0);
    check("arst_wr_mask", 32'(mem_wr_mask), 32'hF);
    check("arst_wr_ack", 32'(port_wr_ack), 32'd0);
    check("arst_port_ack", 32'(port_cmd_ack), 32'd0);
    mem_wr_ack = 1'b0;
    port_cmd_req = 4'hF;
    @(negedge mem_clk);
    mem_rst_n = 1'b1;
    step();
    check("post_rst_req", 32'(mem_cmd_req), 32'd1);
    check("post_rst_grant", 32'(arb_grant), 32'd0);
    check("post_rst_master", 32'(mem_cmd_master), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cram_arb4.md
Name: cram_arb4

Overview:
- Four-port command arbiter that sits directly upstream of the CellularRAM controller (mem_cmd_*/mem_wr_*/mem_rd_* interface).
- Grants one port at a time, round-robin, and forwards that port's command to the controller.
- Steers write data and write acks between the granted port and the controller; routes read beats back by master id.
- Holds the grant until every beat of the transfer has completed.

Parameters:
- ADDR_MASK, 30'h00FF_FFFF, AND-mask applied to the forwarded byte address (16 MB device).
- PORT_EN, 4'b1111, per-port enable; a disabled port is never granted and its outputs stay 0.

Ports:
- mem_clk  in  1  clock
- mem_rst_n  in  1  asynchronous active-low reset
- init_done  in  1  controller initialised; no grant while 0
- port_cmd_req  in  4  per-port command request, level, held until ack
- port_cmd_instr  in  12  3 bits per port; bit0=1 read, bit0=0 write
- port_cmd_bl  in  24  6 bits per port; beats-1 (32-bit words)
- port_cmd_addr  in  120  30-bit byte address per port
- port_cmd_ack  out  4  one-cycle accept pulse per port
- port_wr_data  in  128  32 bits per port, current write word
- port_wr_mask  in  16  4 bits per port, active-high byte mask (1 = byte not written)
- port_wr_ack  out  4  write word consumed; port advances to its next word
- port_rd_valid  out  4  read word valid for that port
- port_rd_data  out  32  read data, broadcast to all ports
- mem_cmd_req, mem_cmd_instr[2:0], mem_cmd_bl[5:0], mem_cmd_byte_addr[29:0], mem_cmd_master[2:0]  out  to controller
- mem_cmd_ack  in  1
- mem_wr_data[31:0], mem_wr_mask[3:0]  out
- mem_wr_ack  in  1
- mem_wr_master  in  3
- mem_rd_req  in  1
- mem_rd_data  in  32
- mem_rd_master  in  3
- arb_busy  out  1  grant held
- arb_grant  out  2  current or last granted port

Behaviour:
- Reset values:
  - mem_cmd_req=0, all mem_cmd_* fields=0, mem_wr_data=0, mem_wr_mask=4'hF.
  - port_cmd_ack=0, port_wr_ack=0, port_rd_valid=0.
  - arb_busy=0, arb_grant=0.
  - Round-robin pointer=0, beat counter=0, state=IDLE.
- Reset mid-transfer clears everything immediately; the controller shares the same reset.
- IDLE:
  - Active when init_done=1 and (port_cmd_req & PORT_EN)!=0.
  - Select the first requesting port starting at rr_ptr, wrapping 3->0.
  - Latch grant g, instr, bl, addr&ADDR_MASK, is_write=~instr[0], and beat counter={1'b0,bl}+1 (7 bits; 1..64).
  - Go to REQ with mem_cmd_req=1 registered, so there is 1-cycle latency from port request to mem_cmd_req.
- REQ:
  - mem_cmd_* are driven from the latched copy and stay stable.
  - mem_cmd_master={1'b0,g}.
  - On mem_cmd_ack=1 at a clock edge: mem_cmd_req<=0, port_cmd_ack[g]<=1 for exactly one cycle, go to XFER.
  - Ports must drop port_cmd_req the cycle after their ack.
- XFER:
  - Write: each mem_wr_ack decrements the counter.
  - Read: each mem_rd_req with mem_rd_master=={1'b0,g} decrements the counter.
  - When a beat arrives with counter==1, go to IDLE and set rr_ptr<=g+1 (mod 4).
- Data path (combinational from grant register g):
  - mem_wr_data/mem_wr_mask = slice g.
  - port_wr_ack = mem_wr_ack ? (1<<g) : 0, valid only in XFER and only when is_write.
  - port_rd_valid[i] = mem_rd_req & (mem_rd_master=={1'b0,i}) & PORT_EN[i].
  - port_rd_data = mem_rd_data.
- arb_busy=1 in REQ and XFER.
- Boundary conditions:
  - Requests arriving during REQ/XFER wait; no preemption.
  - Simultaneous requests resolve by rr_ptr.
  - A port requesting again immediately after its own completion is granted only if no other enabled port requests at that edge.
  - bl=6'h3F gives 64 beats, counter 64; no overflow.
  - mem_wr_ack/mem_rd_req outside XFER are ignored: no counter change, no port strobes. port_rd_valid still decodes by master.
  - Write with mem_rd_req, or read with mem_wr_ack: ignored for counting.
  - init_done falling while busy: the current transfer completes; no new grant.

Optional Feature:
- Macro: CRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when requesting. Remaining ports are round-robin among 1..3; rr_ptr only advances on grants to ports 1..3.
- Undefined: pure 4-way round-robin as above.

Test Plan:
- Port1 write, bl=1, addr 30'h0000_0100, controller model acks mem_cmd_req after 1 cycle:
  - mem_cmd_master=3'b001, mem_cmd_byte_addr=30'h100, port_cmd_ack[1] one-cycle pulse.
  - Two port_wr_ack[1] pulses, then arb_busy=0 and rr_ptr=2.
- Ports 0,2,3 read simultaneously, bl=0 each:
  - Grant order 0,2,3 with round-robin.
  - Grant order 0,0-if-rerequesting,... under CRAM_ARB_FIXED_PRIO_EN.
  - Each port_rd_valid receives exactly one pulse.
- Read bl=6'h3F on port3:
  - Exactly 64 port_rd_valid[3] pulses; returns to IDLE on the 64th pulse, not before.
- Address 30'h3FFF_FFFC with default ADDR_MASK:
  - mem_cmd_byte_addr=30'h00FF_FFFC.
- init_done=0 with port_cmd_req=4'hF:
  - mem_cmd_req stays 0.
  - Raise init_done: mem_cmd_req=1 on the next cycle after the grant edge.
- Assert mem_rst_n=0 mid-write after 3 of 8 beats:
  - All outputs return to reset values asynchronously; next grant starts from port 0.
- PORT_EN=4'b1101 with port1 requesting:
  - Never granted; port_cmd_ack[1]=0 indefinitely.
